// File: rtl/appr_adder_err_stats.sv
// rtl/appr_adder_err_stats.sv - error statistics for an approximate adder under test
// Optional squared-error path built when ERR_STATS_SQ_EN is defined.
module appr_adder_err_stats #(
   parameter int WIDTH    = 32,
   parameter int CNT_W    = 32,
   parameter int ACC_W    = 64,
   parameter int SQ_ACC_W = 96
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CNT_W-1:0]    num_samples,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [WIDTH-1:0]    S,
   input  logic                Cout,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    sample_cnt,
   output logic [ACC_W-1:0]    err_sum,
   output logic [SQ_ACC_W-1:0] err_sq_sum,
   output logic [WIDTH:0]      max_abs_err,
   output logic [CNT_W-1:0]    nz_err_cnt,
   output logic                ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] n_lat;
   logic             drain_cnt;
   logic             hs, last_hs;

   logic [WIDTH:0]   exact_sum;
   logic [WIDTH+1:0] err_now;
   logic             s1_valid;
   logic [WIDTH+1:0] s1_err;

   logic             err_neg;
   logic [WIDTH:0]   err_abs;
   logic [ACC_W-1:0] err_ext, sum_nxt;
   logic             sum_ovf, sq_ovf;

   // start has priority over an offered sample in the same cycle
   assign in_ready = (state == RUN) && (sample_cnt < n_lat) && !start;
   assign hs       = in_valid && in_ready;
   assign last_hs  = hs && (sample_cnt == n_lat - CNT_W'(1));
   assign busy     = (state == RUN) || (state == DRAIN);
   assign done     = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (last_hs) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = DONE;
         default: ;
      endcase
      if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || state != DRAIN) drain_cnt <= 1'b0;
      else                       drain_cnt <= 1'b1;
      if (rst)        n_lat <= '0;
      else if (start) n_lat <= num_samples;
      if (rst || start) sample_cnt <= '0;
      else if (hs)      sample_cnt <= sample_cnt + CNT_W'(1);
   end

   // Stage 1: signed error in WIDTH+2 bits
   assign exact_sum = {1'b0, A} + {1'b0, B};
   assign err_now   = {1'b0, Cout, S} - {1'b0, exact_sum};

   always_ff @(posedge clk) begin
      if (rst || start) s1_valid <= 1'b0;
      else              s1_valid <= hs;
      if (rst)     s1_err <= '0;
      else if (hs) s1_err <= err_now;
   end

   // Stage 2: accumulate
   assign err_neg = s1_err[WIDTH+1];
   assign err_abs = err_neg ? (WIDTH+1)'(-s1_err) : s1_err[WIDTH:0];
   assign err_ext = {{(ACC_W-WIDTH-2){err_neg}}, s1_err};
   assign sum_nxt = err_sum + err_ext;
   assign sum_ovf = (err_sum[ACC_W-1] == err_neg) && (sum_nxt[ACC_W-1] != err_neg);

`ifdef ERR_STATS_SQ_EN
   logic [2*WIDTH+1:0]  err_sq;
   logic [SQ_ACC_W-1:0] sq_nxt;
   logic                sq_carry;

   assign err_sq = (2*WIDTH+2)'(err_abs) * (2*WIDTH+2)'(err_abs);
   assign {sq_carry, sq_nxt} = {1'b0, err_sq_sum} + {1'b0, {(SQ_ACC_W-2*WIDTH-2){1'b0}}, err_sq};
   assign sq_ovf = sq_carry;

   always_ff @(posedge clk) begin
      if (rst || start) err_sq_sum <= '0;
      else if (s1_valid) err_sq_sum <= sq_nxt;
   end
`else
   assign sq_ovf     = 1'b0;
   assign err_sq_sum = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst || start) begin
         err_sum     <= '0;
         max_abs_err <= '0;
         nz_err_cnt  <= '0;
         ovf         <= 1'b0;
      end else if (s1_valid) begin
         err_sum <= sum_nxt;
         if (err_abs >= max_abs_err) max_abs_err <= err_abs;
         if (s1_err != '0) nz_err_cnt <= nz_err_cnt + CNT_W'(1);
         ovf <= ovf | sum_ovf | sq_ovf;
      end
   end

endmodule
